// File: rtl/quad_mixer_n.sv
// Quadrature mixer: synchronises a 1-bit RF comparator sample and mixes it with
// sine/cosine LO samples (sign or multi-bit mode), counting saturated products.
module quad_mixer_n #(
  parameter int SYNC_STAGES = 2,
  parameter int LO_W        = 8,
  parameter int OUT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             rf_in,
  input  logic [LO_W-1:0]  lo_sin,
  input  logic [LO_W-1:0]  lo_cos,
  input  logic             mode,
  input  logic             iq_swap,
  output logic [OUT_W-1:0] mix_sin,
  output logic [OUT_W-1:0] mix_cos,
  output logic             valid,
  output logic [15:0]      sat_cnt
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rf_s;
  logic [LO_W-1:0]        a_sin_q, a_sin_d, a_cos_q, a_cos_d;
  logic                   a_rf_q, a_rf_d, a_mode_q, a_mode_d, a_swap_q, a_swap_d;
  logic [OUT_W-1:0]       mix_sin_q, mix_sin_d, mix_cos_q, mix_cos_d;
  logic                   va_q, va_d, valid_q, valid_d;
  logic [15:0]            sat_cnt_q, sat_cnt_d;
  logic [LO_W-1:0]        path_sin_lo_s, path_cos_lo_s;
  logic [OUT_W:0]         res_sin_s, res_cos_s;
  logic [16:0]            sat_sum_s;

  // Returns {saturated, product}; negation is done one bit wider so that only
  // -2^(LO_W-1) with OUT_W == LO_W can overflow.
  function automatic logic [OUT_W:0] mix_path(input logic [LO_W-1:0] lo,
                                              input logic rf,
                                              input logic mode_i);
    logic signed [LO_W:0]  neg_v;
    logic signed [OUT_W:0] wide_v;
    logic [OUT_W:0]        res;
    neg_v  = {(LO_W+1){1'b0}};
    wide_v = {(OUT_W+1){1'b0}};
    res    = {(OUT_W+1){1'b0}};
    if (!mode_i) begin
      if (lo[LO_W-1] == rf) begin
        res = {1'b0, {(OUT_W-1){1'b0}}, 1'b1};
      end else begin
        res = {1'b0, {OUT_W{1'b1}}};
      end
    end else if (!rf) begin
      wide_v = (OUT_W+1)'(signed'(lo));
      res    = {1'b0, wide_v[OUT_W-1:0]};
    end else begin
      neg_v  = -((LO_W+1)'(signed'(lo)));
      wide_v = (OUT_W+1)'(neg_v);
      if (wide_v[OUT_W] != wide_v[OUT_W-1]) begin
        res = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
      end else begin
        res = {1'b0, wide_v[OUT_W-1:0]};
      end
    end
    return res;
  endfunction

  assign rf_s = sync_q[SYNC_STAGES-1];

  // Path selection, products and saturating counter arithmetic
  always_comb begin
    if (a_swap_q) begin
      path_sin_lo_s = a_cos_q;
      path_cos_lo_s = a_sin_q;
    end else begin
      path_sin_lo_s = a_sin_q;
      path_cos_lo_s = a_cos_q;
    end
    res_sin_s = mix_path(path_sin_lo_s, a_rf_q, a_mode_q);
    res_cos_s = mix_path(path_cos_lo_s, a_rf_q, a_mode_q);
    sat_sum_s = {1'b0, sat_cnt_q} + {16'd0, res_sin_s[OUT_W]} + {16'd0, res_cos_s[OUT_W]};
  end

  // Next-state for synchroniser, both pipeline stages and the valid chain
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], rf_in};
    va_d      = en;
    valid_d   = va_q;
    a_sin_d   = a_sin_q;
    a_cos_d   = a_cos_q;
    a_rf_d    = a_rf_q;
    a_mode_d  = a_mode_q;
    a_swap_d  = a_swap_q;
    mix_sin_d = mix_sin_q;
    mix_cos_d = mix_cos_q;
    sat_cnt_d = sat_cnt_q;
    if (en) begin
      a_sin_d   = lo_sin;
      a_cos_d   = lo_cos;
      a_rf_d    = rf_s;
      a_mode_d  = mode;
      a_swap_d  = iq_swap;
      mix_sin_d = res_sin_s[OUT_W-1:0];
      mix_cos_d = res_cos_s[OUT_W-1:0];
      if (sat_sum_s[16]) begin
        sat_cnt_d = 16'hFFFF;
      end else begin
        sat_cnt_d = sat_sum_s[15:0];
      end
    end else begin
      sat_cnt_d = sat_cnt_q;
    end
  end

  // State registers; synchroniser and stage-A rf reset to 1, everything else to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= {SYNC_STAGES{1'b1}};
      a_sin_q   <= {LO_W{1'b0}};
      a_cos_q   <= {LO_W{1'b0}};
      a_rf_q    <= 1'b1;
      a_mode_q  <= 1'b0;
      a_swap_q  <= 1'b0;
      mix_sin_q <= {OUT_W{1'b0}};
      mix_cos_q <= {OUT_W{1'b0}};
      va_q      <= 1'b0;
      valid_q   <= 1'b0;
      sat_cnt_q <= 16'd0;
    end else begin
      sync_q    <= sync_d;
      a_sin_q   <= a_sin_d;
      a_cos_q   <= a_cos_d;
      a_rf_q    <= a_rf_d;
      a_mode_q  <= a_mode_d;
      a_swap_q  <= a_swap_d;
      mix_sin_q <= mix_sin_d;
      mix_cos_q <= mix_cos_d;
      va_q      <= va_d;
      valid_q   <= valid_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign mix_sin = mix_sin_q;
  assign mix_cos = mix_cos_q;
  assign valid   = valid_q;
  assign sat_cnt = sat_cnt_q;

endmodule

// File: doc/quad_mixer_n.md
QUAD_MIXER_N -- requirements
Module: quad_mixer_n

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the rf_in synchroniser depth (legal values 2..8).
REQ-002 The block SHALL have parameter LO_W, default 8, giving the width of the signed two's-complement LO samples (legal values 2..16).
REQ-003 The block SHALL have parameter OUT_W, default 8, giving the width of the signed mixer outputs (legal values OUT_W >= LO_W).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge triggered.
REQ-005 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The block SHALL have port en, input, 1 bit: clock enable for the mixing pipeline.
REQ-007 The block SHALL have port rf_in, input, 1 bit: the asynchronous 1-bit RF comparator sample.
REQ-008 The block SHALL have port lo_sin, input, LO_W bits: the signed sine LO sample.
REQ-009 The block SHALL have port lo_cos, input, LO_W bits: the signed cosine LO sample.
REQ-010 The block SHALL have port mode, input, 1 bit: 0 selects sign mixing, 1 selects multi-bit LO mixing.
REQ-011 The block SHALL have port iq_swap, input, 1 bit: when 1, exchanges the sine and cosine paths for spectral inversion.
REQ-012 The block SHALL have port mix_sin, output, OUT_W bits: the signed sine-path product.
REQ-013 The block SHALL have port mix_cos, output, OUT_W bits: the signed cosine-path product.
REQ-014 The block SHALL have port valid, output, 1 bit: high for one cycle per new output sample.
REQ-015 The block SHALL have port sat_cnt, output, 16 bits: the count of saturated products.

Function
REQ-016 rf_in SHALL pass through a SYNC_STAGES-deep flip-flop chain that runs every cycle, regardless of en; rf_s is the last stage.
REQ-017 Stage A SHALL register lo_sin, lo_cos, rf_s, mode and iq_swap only when en=1, and hold them otherwise.
REQ-018 Stage B SHALL compute mix_sin and mix_cos from stage A contents only when en=1, and hold its outputs otherwise.
REQ-019 The valid pipeline SHALL be va <= en; valid <= va, so valid is en delayed by 2 cycles; this pipeline is not itself gated by en.
REQ-020 Latency SHALL be 2 cycles from LO/mode/iq_swap to output, and SYNC_STAGES+2 cycles from rf_in to output.
REQ-021 With iq_swap=0, the sine path SHALL use stage-A lo_sin and the cosine path lo_cos; with iq_swap=1, the sine path SHALL use lo_cos and the cosine path lo_sin.
REQ-022 In mode 0, each path SHALL output +1 when rf_s equals the LO MSB, else -1 (all ones), sign-extended to OUT_W.
REQ-023 In mode 1 with rf_s=0, each path SHALL output the LO sample sign-extended to OUT_W.
REQ-024 In mode 1 with rf_s=1, each path SHALL output the negated LO sample, sign-extended to OUT_W.
REQ-025 In mode 1, negating the most negative LO value (-2^(LO_W-1)) SHALL saturate to +2^(LO_W-1)-1 when OUT_W = LO_W; when OUT_W > LO_W it SHALL be represented exactly and SHALL NOT count as saturation.
REQ-026 Each saturating path SHALL increment sat_cnt by 1 in the cycle stage B updates.
REQ-027 If both paths saturate in the same cycle, sat_cnt SHALL increment by 2.
REQ-028 sat_cnt SHALL stick at 16'hFFFF and SHALL NOT wrap.
REQ-029 A mode or iq_swap change SHALL take effect on the first sample registered in stage A after the change; there is no glitch or mixed sample.

Reset
REQ-030 While rst_n=0, all synchroniser flops and the stage-A rf register SHALL be 1.
REQ-031 While rst_n=0, the stage-A LO registers, mix_sin and mix_cos SHALL be 0.
REQ-032 While rst_n=0, va, valid and sat_cnt SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL clear the state immediately and asynchronously, with no partial sample emitted afterwards.
REQ-034 After rst_n deasserts, the first valid=1 SHALL occur 2 cycles after the first cycle with en=1.

Verification
REQ-035 Mode 0, LO_W=8, OUT_W=8, en=1, lo_sin=8'h7F, lo_cos=8'h80, rf_in held 0 -> mix_sin=8'h01 and mix_cos=8'hFF; toggling rf_in to 1 -> both outputs invert SYNC_STAGES+2 cycles later.
REQ-036 Mode 1, OUT_W=8, lo_sin=8'h80, rf_s=1 -> mix_sin=8'h7F, sat_cnt increments by 1 per cycle; with lo_cos=8'h80 too -> increments by 2 per cycle; at 16'hFFFE the counter stops at 16'hFFFF.
REQ-037 Mode 1, OUT_W=12, lo_sin=8'h80, rf_s=1 -> mix_sin=12'h080 and sat_cnt unchanged; with rf_s=0 and lo_cos=8'h05 -> mix_cos=12'h005.
REQ-038 Toggle iq_swap with lo_sin=3, lo_cos=-3 in mode 1, rf_s=0 -> outputs exchange exactly 2 cycles after the toggle, with no intermediate values.
REQ-039 en pattern 1,0,0,1 -> valid follows the pattern with 2 cycles of delay and outputs hold during the en=0 cycles; rst_n pulsed low for 1 cycle mid-stream -> all outputs 0 and sync flops 1 immediately, with no spurious valid afterwards.
